// File: rtl/svreal_chan_accum_if.sv
// Sample-in / window-result-out handshake bundle for svreal_chan_accum.
// master drives samples and out_ready; slave is the accumulator.
interface svreal_chan_accum_if #(
  parameter int CW        = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24
);
  logic                        in_valid;
  logic                        in_ready;
  logic [CW-1:0]               in_ch;
  logic signed [IN_WIDTH-1:0]  in_value;
  logic                        out_valid;
  logic                        out_ready;
  logic [CW-1:0]               out_ch;
  logic signed [OUT_WIDTH-1:0] out_value;
  logic                        out_sat;

  modport master (
    output in_valid, in_ch, in_value, out_ready,
    input  in_ready, out_valid, out_ch, out_value, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_value, out_ready,
    output in_ready, out_valid, out_ch, out_value, out_sat
  );
endinterface

// File: rtl/svreal_chan_accum.sv
// N-channel windowed svreal accumulator with saturating add.
// ACCUM_ROUND_EN: round half-up (instead of truncate) on right-shift alignment.
module svreal_chan_accum #(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 16,
  parameter int IN_EXP    = -8,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_EXP   = -10,
  parameter int LEN       = 8
) (
  input logic               clk,
  input logic               rst,
  svreal_chan_accum_if.slave bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int D  = IN_EXP - OUT_EXP;
  localparam int SH = (D >= 0) ? D : -D;
  localparam int W  = ((OUT_WIDTH > IN_WIDTH + SH) ?
                       OUT_WIDTH : IN_WIDTH + SH) + 2;
  localparam logic [NW-1:0] LAST = NW'(LEN - 1);
  localparam logic signed [W-1:0] MAXV =
    {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MINV =
    {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef ACCUM_ROUND_EN
  localparam int RS = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [W-1:0] RND = W'(1) << RS;
`endif

  logic signed [OUT_WIDTH-1:0] acc [N_CH];
  logic [NW-1:0]               cnt [N_CH];
  logic [N_CH-1:0]             sat;

  logic                        ov;
  logic [CW-1:0]               och;
  logic signed [OUT_WIDTH-1:0] oval;
  logic                        osat;

  logic                        ch_ok;
  logic [CW-1:0]               ch;
  logic                        take;
  logic                        last;
  logic                        clamp;
  logic signed [W-1:0]         x;
  logic signed [W-1:0]         al;
  logic signed [W-1:0]         sum;
  logic signed [OUT_WIDTH-1:0] sum_c;

  assign bus.in_ready  = !rst && (!ov || bus.out_ready);
  assign bus.out_valid = ov;
  assign bus.out_ch    = och;
  assign bus.out_value = oval;
  assign bus.out_sat   = osat;

  // out-of-range channels are consumed but never touch state
  assign ch_ok = 32'(bus.in_ch) < N_CH;
  assign ch    = ch_ok ? bus.in_ch : '0;
  assign take  = bus.in_valid && bus.in_ready && ch_ok;
  assign last  = cnt[ch] == LAST;

  always_comb begin
    x     = W'(bus.in_value);
    al    = x;
    if (D >= 0) begin
      al = x <<< SH;
    end else begin
`ifdef ACCUM_ROUND_EN
      al = (x + RND) >>> SH;
`else
      al = x >>> SH;
`endif
    end
    sum   = W'(acc[ch]) + al;
    clamp = (sum > MAXV) || (sum < MINV);
    if (sum > MAXV)
      sum_c = MAXV[OUT_WIDTH-1:0];
    else if (sum < MINV)
      sum_c = MINV[OUT_WIDTH-1:0];
    else
      sum_c = sum[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      sat  <= '0;
      ov   <= 1'b0;
      och  <= '0;
      oval <= '0;
      osat <= 1'b0;
    end else begin
      if (ov && bus.out_ready)
        ov <= 1'b0;
      if (take) begin
        if (last) begin
          oval    <= sum_c;
          osat    <= sat[ch] | clamp;
          och     <= ch;
          ov      <= 1'b1;
          acc[ch] <= '0;
          cnt[ch] <= '0;
          sat[ch] <= 1'b0;
        end else begin
          acc[ch] <= sum_c;
          cnt[ch] <= cnt[ch] + 1'b1;
          sat[ch] <= sat[ch] | clamp;
        end
      end
    end
  end
endmodule
